t05_huffman_decoder: RTL

- Inverse of the compression path: walks the stored Huffman tree one bit at a time to turn a packed bitstream back into 8-bit characters.
- Node IDs use the codebase's 9-bit format:
  - bit8=0: leaf, bits[7:0] are the character.
  - bit8=1: internal node, bits[7:0] are the node-table index.
  - 9'h180 (384) is the null/sentinel ID.
- Sits between the SRAM node-table arbiter and the output character FIFO.

---
 rtl/t05_huffman_decoder_pkg.sv | 40 ++++
 rtl/t05_huffman_decoder_if.sv | 35 +++
 rtl/t05_huffman_decoder_bitbuf.sv | 54 +++++
 rtl/t05_huffman_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/t05_huffman_decoder_pkg.sv
// ---------------------------------------------------------------------------
// t05_hdec_pkg
// Shared types and helpers for the Huffman decoder slice.
//   - 9-bit node ID format: bit8=0 leaf (bits[7:0] = character),
//     bit8=1 internal node (bits[7:0] = node-table index).
//   - NODE_NULL marks an absent child / invalid root.
//   - node_t is the 18-bit node-table word {left_child, right_child}.
// ---------------------------------------------------------------------------
package t05_hdec_pkg;

    localparam logic [8:0] NODE_NULL = 9'h180;

    // State encodings kept as plain constants so older code that compares
    // against raw 3-bit values keeps working.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WALK  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_EMIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        WALK  = ST_WALK,
        LOAD  = ST_LOAD,
        FETCH = ST_FETCH,
        EMIT  = ST_EMIT,
        DONE  = ST_DONE
    } state_e;

    typedef struct packed {
        logic [8:0] left;
        logic [8:0] right;
    } node_t;

    function automatic logic is_leaf(input logic [8:0] node);
        return ~node[8];
    endfunction

endpackage

// File: rtl/t05_huffman_decoder_if.sv
// ---------------------------------------------------------------------------
// t05_huffman_decoder_if
// Groups the three handshaked buses of the decoder:
//   bitstream in : bit_data, bit_valid, bit_ready
//   node table   : node_req, node_addr, node_ack, node_data
//   char out     : char_out, char_valid, char_ready
// master = decoder side, slave = bitstream source / arbiter / FIFO side.
// ---------------------------------------------------------------------------
interface t05_huffman_decoder_if;
    import t05_hdec_pkg::*;

    logic [7:0] bit_data;
    logic       bit_valid;
    logic       bit_ready;

    logic       node_req;
    logic [7:0] node_addr;
    logic       node_ack;
    node_t      node_data;

    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;

    modport master (
        input  bit_data, bit_valid, node_ack, node_data, char_ready,
        output bit_ready, node_req, node_addr, char_out, char_valid
    );

    modport slave (
        output bit_data, bit_valid, node_ack, node_data, char_ready,
        input  bit_ready, node_req, node_addr, char_out, char_valid
    );

endinterface

// File: rtl/t05_huffman_decoder_bitbuf.sv
// ---------------------------------------------------------------------------
// t05_hdec_bitbuf
// One-byte bitstream buffer: loads a byte when requested, hands out bits
// MSB first and tracks how many remain.
// Ports:
//   clk, rst    clock, async active-high reset
//   clear       drop any buffered bits (new decode starting)
//   load_en     decoder wants a byte; drives bit_ready
//   bit_data    incoming byte, bit_valid qualifies it
//   shift       consume the current bit (ignored when empty)
//   bit_ready   byte accepted this cycle when bit_valid is also high
//   load_done   byte handshake happening this cycle
//   cur_bit     bit to be consumed next (shreg[7])
//   bits_left   number of unconsumed bits, 0..8
// ---------------------------------------------------------------------------
module t05_hdec_bitbuf (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load_en,
    input  logic [7:0] bit_data,
    input  logic       bit_valid,
    input  logic       shift,
    output logic       bit_ready,
    output logic       load_done,
    output logic       cur_bit,
    output logic [3:0] bits_left
);

    logic [7:0] shreg;

    assign bit_ready = load_en;
    assign load_done = load_en & bit_valid;
    assign cur_bit   = shreg[7];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= 8'h00;
            bits_left <= 4'd0;
        end else if (clear) begin
            shreg     <= 8'h00;
            bits_left <= 4'd0;
        end else if (load_done) begin
            shreg     <= bit_data;
            bits_left <= 4'd8;
        end else if (shift && (bits_left != 4'd0)) begin
            shreg     <= {shreg[6:0], 1'b0};
            bits_left <= bits_left - 4'd1;
        end
    end

endmodule

// File: rtl/t05_huffman_decoder.sv
// ---------------------------------------------------------------------------
// t05_huffman_decoder
// Walks the stored Huffman tree one bit at a time, turning a packed
// MSB-first bitstream back into 8-bit characters.
// Ports:
//   clk, rst      clock, async active-high reset (aborts any decode)
//   start         one-cycle pulse, honoured only in IDLE/DONE
//   root_node     9-bit root node ID, latched on start
//   char_count    characters to emit, latched on start
//   bus           bitstream / node-table / char-out handshakes (master)
//   busy          high outside IDLE/DONE
//   done          high in DONE until the next start
//   err           sticky null-child / null-root flag, cleared on start
// Build option:
//   T05_HDEC_ROOT_CACHE_EN - fetch the root word once per decode and resolve
//   every root step from a local copy, saving one node read per character.
// ---------------------------------------------------------------------------
module t05_huffman_decoder
    import t05_hdec_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NODE_W = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NODE_W-1:0]     root_node,
    input  logic [CNT_W-1:0]      char_count,
    t05_huffman_decoder_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_e            state;
    logic [NODE_W-1:0] cur;
    logic [NODE_W-1:0] root_q;
    logic [CNT_W-1:0]  remaining;
    logic [7:0]        char_q;
    logic              err_q;

    logic              start_ok;
    logic              step;       // a child is selected this cycle
    logic              shift;
    logic              use_cache;
    logic              root_fetch;
    logic              load_done;
    logic              cur_bit;
    logic [3:0]        bits_left;
    node_t             sel_word;
    logic [NODE_W-1:0] child;

`ifdef T05_HDEC_ROOT_CACHE_EN
    node_t root_word;
    logic  root_fetch_q;            // the pending FETCH is the one-off root load

    assign root_fetch = root_fetch_q;
    assign use_cache  = (state == WALK) && (bits_left != 4'd0) &&
                        !is_leaf(cur) && (cur == root_q);
`else
    assign root_fetch = 1'b0;
    assign use_cache  = 1'b0;
`endif

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign step     = use_cache ||
                      ((state == FETCH) && bus.node_ack && !root_fetch);
    // A leaf root still consumes one bit per character.
    assign shift    = step ||
                      ((state == WALK) && (bits_left != 4'd0) && is_leaf(cur));

    // NOTE: every combinational output gets a default before any condition,
    // otherwise a missed branch infers a latch.
    always_comb begin
        sel_word = bus.node_data;
`ifdef T05_HDEC_ROOT_CACHE_EN
        if (use_cache) sel_word = root_word;
`endif
        child = cur_bit ? sel_word.right : sel_word.left;
    end

    t05_hdec_bitbuf u_bitbuf (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .load_en   (state == LOAD),
        .bit_data  (bus.bit_data),
        .bit_valid (bus.bit_valid),
        .shift     (shift),
        .bit_ready (bus.bit_ready),
        .load_done (load_done),
        .cur_bit   (cur_bit),
        .bits_left (bits_left)
    );

    // NOTE: all control and data registers are reset; there is no memory
    // array here, so resetting everything costs nothing and keeps restarts
    // after an abort deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            root_q       <= '0;
            remaining    <= '0;
            char_q       <= 8'h00;
            err_q        <= 1'b0;
`ifdef T05_HDEC_ROOT_CACHE_EN
            root_word    <= '0;
            root_fetch_q <= 1'b0;
`endif
        end else if (start_ok) begin
            root_q    <= root_node;
            cur       <= root_node;
            remaining <= char_count;
            err_q     <= 1'b0;
            if (char_count == '0) begin
                state <= DONE;
            end else if (root_node == NODE_NULL) begin
                err_q <= 1'b1;
                state <= DONE;
`ifdef T05_HDEC_ROOT_CACHE_EN
            end else if (!is_leaf(root_node)) begin
                root_fetch_q <= 1'b1;
                state        <= FETCH;
`endif
            end else begin
                state <= WALK;
            end
        end else if (step) begin
            if (child == NODE_NULL) begin
                err_q <= 1'b1;
                state <= DONE;
            end else if (is_leaf(child)) begin
                char_q <= child[7:0];
                state  <= EMIT;
            end else begin
                cur   <= child;
                state <= WALK;
            end
        end else begin
            case (state)
                WALK: begin
                    if (bits_left == 4'd0) begin
                        state <= LOAD;
                    end else if (is_leaf(cur)) begin
                        char_q <= cur[7:0];
                        state  <= EMIT;
                    end else begin
                        state <= FETCH;
                    end
                end
                LOAD: begin
                    if (load_done) state <= WALK;
                end
`ifdef T05_HDEC_ROOT_CACHE_EN
                FETCH: begin
                    if (bus.node_ack) begin
                        root_word    <= bus.node_data;
                        root_fetch_q <= 1'b0;
                        state        <= WALK;
                    end
                end
`endif
                EMIT: begin
                    if (bus.char_ready) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end else begin
                            cur   <= root_q;
                            state <= WALK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.node_req   = (state == FETCH);
    assign bus.node_addr  = (state == FETCH) ? cur[7:0] : 8'h00;
    assign bus.char_valid = (state == EMIT);
    assign bus.char_out   = (state == EMIT) ? char_q : 8'h00;
    assign busy           = (state != IDLE) && (state != DONE);
    assign done           = (state == DONE);
    assign err            = err_q;

endmodule
